// File: rtl/charmem_scroll_ctrl.sv
// Data-port arbiter for the 128x32 character/colour memory: the CPU always wins, and a
// background engine runs CLEAR and SCROLL_UP in the cycles the CPU leaves free.
module charmem_scroll_ctrl #(
    parameter int unsigned COLS = 128,
    parameter int unsigned ROWS = 32,
    parameter int unsigned AW   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [31:0]   cmd_fill,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [AW-1:0] LastAddr = AW'(COLS * ROWS - 1);
    localparam logic [AW-1:0] ColsAddr = AW'(COLS);
    localparam logic [AW-1:0] FillBase = AW'((ROWS - 1) * COLS);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StScrRd,
        StScrWr,
        StScrFill
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [31:0]   fill_q, fill_d;
    logic [31:0]   hold_q, hold_d;
    logic          rd_pend_q, rd_pend_d;
    logic          done_q, done_d;

    logic          eng_slot;
    logic          eng_req;
    logic          eng_we;
    logic [AW-1:0] eng_addr;
    logic [31:0]   eng_wdata;
    logic [31:0]   moved_word;

    assign eng_slot = ~cpu_req;
    // The write of a scroll pair may follow its read directly, before hold_q is loaded.
    assign moved_word = rd_pend_q ? mem_rdata : hold_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fill_d    = fill_q;
        hold_d    = hold_q;
        rd_pend_d = 1'b0;
        done_d    = 1'b0;
        eng_req   = 1'b0;
        eng_we    = 1'b0;
        eng_addr  = '0;
        eng_wdata = '0;

        // Read data is captured even when the CPU owns this cycle.
        if (rd_pend_q) begin
            hold_d = mem_rdata;
        end

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    fill_d = cmd_fill;
                    if (cmd_op) begin
                        state_d = StScrRd;
                        cnt_d   = ColsAddr;
                    end else begin
                        state_d = StClr;
                        cnt_d   = '0;
                    end
                end
            end
            StClr: begin
                if (eng_slot) begin
                    eng_req   = 1'b1;
                    eng_we    = 1'b1;
                    eng_addr  = cnt_q;
                    eng_wdata = fill_q;
                    if (cnt_q == LastAddr) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            StScrRd: begin
                if (eng_slot) begin
                    eng_req   = 1'b1;
                    eng_addr  = cnt_q;
                    rd_pend_d = 1'b1;
                    state_d   = StScrWr;
                end
            end
            StScrWr: begin
                if (eng_slot) begin
                    eng_req   = 1'b1;
                    eng_we    = 1'b1;
                    eng_addr  = cnt_q - ColsAddr;
                    eng_wdata = moved_word;
                    if (cnt_q == LastAddr) begin
                        state_d = StScrFill;
                        cnt_d   = FillBase;
                    end else begin
                        state_d = StScrRd;
                        cnt_d   = cnt_q + AW'(1);
                    end
                end
            end
            StScrFill: begin
                if (eng_slot) begin
                    eng_req   = 1'b1;
                    eng_we    = 1'b1;
                    eng_addr  = cnt_q;
                    eng_wdata = fill_q;
                    if (cnt_q == LastAddr) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            fill_q    <= '0;
            hold_q    <= '0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fill_q    <= fill_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
            done_q    <= done_d;
        end
    end

    // Port held quiet while reset is asserted so an aborted command cannot land one more write.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rst_n) begin
            if (cpu_req) begin
                mem_addr  = cpu_addr;
                mem_we    = cpu_we;
                mem_wdata = cpu_wdata;
            end else if (eng_req) begin
                mem_addr  = eng_addr;
                mem_we    = eng_we;
                mem_wdata = eng_wdata;
            end
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_charmem_scroll_ctrl.sv
// Bench for charmem_scroll_ctrl: behavioural 4096-word memory, command table, CPU-read
// scoreboard, and hand-written reset sequences.
module tb_charmem_scroll_ctrl;

    localparam int unsigned COLS  = 128;
    localparam int unsigned ROWS  = 32;
    localparam int unsigned AW    = 12;
    localparam int unsigned WORDS = COLS * ROWS;
    localparam int unsigned PAIRS = WORDS - COLS;
    localparam int unsigned LAST  = WORDS - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [31:0]   cpu_wdata = '0;
    logic [31:0]   cpu_rdata;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_op = 1'b0;
    logic [31:0]   cmd_fill = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    charmem_scroll_ctrl #(
        .COLS(COLS),
        .ROWS(ROWS),
        .AW  (AW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_fill (cmd_fill),
        .busy     (busy),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [WORDS];
    logic [31:0] pre [WORDS];
    logic        load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int a = 0; a < WORDS; a++) mem[a] <= pre[a];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] sb_q [$];
    bit          rd_prev = 1'b0;

    typedef struct {
        logic        op;
        logic [31:0] fill;
        int          mode;      // 0 none, 1 read addr 5 every 3rd cycle, 2 steal after reads, 3 held cmd
        int          base_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_cycle(input logic req, input logic we, input logic [AW-1:0] addr,
                            input logic [31:0] wd, input logic [31:0] exp, input logic cv,
                            input logic op, input logic [31:0] fill);
        @(posedge clk);
        #1;
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        cmd_valid = cv;
        cmd_op    = op;
        cmd_fill  = fill;
        if (req && !we) sb_q.push_back(exp);
        @(negedge clk);
        if (rd_prev) begin
            if (sb_q.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
            else check("cpu_rdata", cpu_rdata, sb_q.pop_front());
        end
        rd_prev = req && !we;
    endtask

    task automatic idle_cycle();
        do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic load_mem(input logic scroll_pat);
        for (int a = 0; a < WORDS; a++) pre[a] = scroll_pat ? 32'(a) : (32'(a) ^ 32'hA5A5_0000);
        @(posedge clk);
        #1;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic check_image(input string name, input logic op, input logic [31:0] fill,
                               input int limit);
        int          first;
        int          nwrong;
        logic [31:0] w;
        logic [31:0] got_first;
        logic [31:0] exp_first;
        first = -1;
        nwrong = 0;
        got_first = '0;
        exp_first = '0;
        for (int a = 0; a < WORDS; a++) begin
            if (op) w = (a < PAIRS) ? pre[a + COLS] : fill;
            else w = (a < limit) ? fill : pre[a];
            if (mem[a] !== w) begin
                nwrong++;
                if (first < 0) begin
                    first = a;
                    got_first = mem[a];
                    exp_first = w;
                end
            end
        end
        n_cmp++;
        if (nwrong != 0) begin
            n_bad++;
            $display("FAIL %s: word %0d got %h expected %h (%0d words wrong)", name, first,
                     got_first, exp_first, nwrong);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          e;
        int          n_cpu;
        int          lat;
        int          ready_bad;
        int          busy_bad;
        int          lat2;
        bit          prev_eng_rd;
        bit          got_done;
        logic        req;
        logic [AW-1:0] addr;
        logic [31:0] exp;
        logic        d_busy;
        logic        d_ready;
        string       tag;
        tag = $sformatf("vec%0d", idx);
        e = 0; n_cpu = 0; lat = 0; ready_bad = 0; busy_bad = 0;
        prev_eng_rd = 1'b0; got_done = 1'b0; d_busy = 1'b1; d_ready = 1'b0;

        load_mem(v.op);
        do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, v.op, v.fill);
        check({tag, "_ready_at_accept"}, 32'(cmd_ready), 32'd1);

        for (int k = 1; k <= 20000 && !got_done; k++) begin
            req = 1'b0;
            addr = '0;
            exp = '0;
            if (v.mode == 1 && (k % 3) == 0) begin
                req = 1'b1;
                addr = AW'(5);
                exp = (e > 11) ? 32'd133 : 32'd5;
            end else if (v.mode == 2 && prev_eng_rd) begin
                req = 1'b1;
                addr = AW'(LAST);
                exp = 32'(LAST);
            end
            do_cycle(req, 1'b0, addr, '0, exp, v.mode == 3, 1'b0, 32'hDEAD_BEEF);
            if (!req) begin
                prev_eng_rd = v.op && (e < 2 * PAIRS) && ((e % 2) == 0);
                e++;
            end else begin
                prev_eng_rd = 1'b0;
            end
            if (done) begin
                got_done = 1'b1;
                lat = k;
                d_busy = busy;
                d_ready = cmd_ready;
            end else begin
                if (!busy) busy_bad++;
                if (cmd_ready) ready_bad++;
                if (req) n_cpu++;
            end
        end

        if (!got_done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(v.base_lat + n_cpu));
        check({tag, "_busy_during_cmd"}, 32'(busy_bad), 32'd0);
        check({tag, "_ready_while_busy"}, 32'(ready_bad), 32'd0);
        check({tag, "_busy_at_done"}, 32'(d_busy), 32'd0);
        check({tag, "_ready_at_done"}, 32'(d_ready), 32'd1);

        idle_cycle();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after_done"}, 32'(busy), (v.mode == 3) ? 32'd1 : 32'd0);
        check_image({tag, "_image"}, v.op, v.fill, WORDS);

        if (v.mode == 3) begin
            got_done = 1'b0;
            lat2 = 0;
            for (int k = 2; k <= 20000 && !got_done; k++) begin
                idle_cycle();
                if (done) begin
                    got_done = 1'b1;
                    lat2 = k;
                end
            end
            check({tag, "_held_clear_latency"}, 32'(lat2), 32'd4097);
            check_image({tag, "_held_clear_image"}, 1'b0, 32'hDEAD_BEEF, WORDS);
        end
        idle_cycle();
    endtask

    initial begin
        vecs[0] = '{op: 1'b0, fill: 32'h00F0_0020, mode: 0, base_lat: 4097};
        vecs[1] = '{op: 1'b1, fill: 32'h0000_0041, mode: 0, base_lat: 8065};
        vecs[2] = '{op: 1'b1, fill: 32'h0000_0041, mode: 1, base_lat: 8065};
        vecs[3] = '{op: 1'b1, fill: 32'h0000_0041, mode: 2, base_lat: 8065};
        vecs[4] = '{op: 1'b1, fill: 32'h1234_5678, mode: 3, base_lat: 8065};

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            cpu_req   = 1'($urandom_range(0, 1));
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = AW'($urandom);
            cpu_wdata = $urandom;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 1'($urandom_range(0, 1));
            cmd_fill  = $urandom;
            @(negedge clk);
            check("mem_we_in_reset", 32'(mem_we), 32'd0);
        end
        rst_n = 1'b1;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cmd_valid = 1'b0;
        idle_cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset in the cycle that would write word 1000 of a CLEAR.
        load_mem(1'b0);
        do_cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, 32'hCAFE_BABE);
        for (int k = 0; k < 1000; k++) idle_cycle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midclr_mem_we_in_reset", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midclr_busy_after_reset", 32'(busy), 32'd0);
        check("midclr_done_after_reset", 32'(done), 32'd0);
        idle_cycle();
        idle_cycle();
        check_image("midclr_image", 1'b0, 32'hCAFE_BABE, 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/charmem_scroll_ctrl.md
Name: charmem_scroll_ctrl

Overview:
Owns the processor-side (data) port of the 128x32 character/colour memory, which has 4096 32-bit words and a 1-cycle synchronous read. It shares that port between the CPU and an internal engine that runs two commands: CLEAR (fill the whole screen) and SCROLL_UP (move rows 1..31 up by one row, then fill row 31). The CPU has absolute per-cycle priority, and the engine runs in the cycles the CPU leaves free. The VGA port is not touched.

Parameters:
COLS, 128, characters per row; power of two.
ROWS, 32, rows per screen.
AW, 12, word-address width; log2(COLS*ROWS).

Ports:
clk  in  1  data clock; the only clock.
rst_n  in  1  synchronous reset, active low.
cpu_req  in  1  CPU access this cycle.
cpu_we  in  1  CPU write enable; qualified by cpu_req.
cpu_addr  in  AW  CPU word address.
cpu_wdata  in  32  CPU write data.
cpu_rdata  out  32  CPU read data; valid the cycle after a CPU read.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE.
cmd_op  in  1  0=CLEAR, 1=SCROLL_UP.
cmd_fill  in  32  fill word {bg[31:20], fg[19:8], char[7:0]}.
busy  out  1  engine active.
done  out  1  one-cycle pulse at command completion.
mem_addr  out  AW  to memory data_addr.
mem_we  out  1  to memory data_we.
mem_wdata  out  32  to memory data_write_value.
mem_rdata  in  32  from memory data_read_value.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0. rd_pend and the counters clear. Reset mid-command aborts it; memory is left partially updated, with no further writes.
- Port mux (combinational): cpu_req=1 drives mem_addr/we/wdata from the CPU. Otherwise the engine drives them. With no engine access, mem_we=0.
- cpu_rdata = mem_rdata (pass-through). The CPU never stalls, and its accesses are always granted.
- Command accept: cmd_valid & cmd_ready at edge t. cmd_op and cmd_fill are latched. busy=1 from t+1, and the first engine access is possible in cycle t+1. cmd_valid while busy is ignored; nothing is queued.
- States: IDLE, CLR, SCR_RD, SCR_WR, SCR_FILL.
- CLR: writes fill to addr 0..4095 ascending, one word per engine cycle. After addr 4095 is written, go to IDLE.
- SCR_RD: reads src. src starts at COLS (128). Sets rd_pend. Next state is SCR_WR.
- SCR_WR: writes hold to src-COLS, then src++. If src was 4095, go to SCR_FILL with dst=3968; otherwise go to SCR_RD.
- SCR_FILL: writes fill to 3968..4095. After 4095, go to IDLE.
- rd_pend rule: on the cycle after an engine read, hold <= mem_rdata, even if the CPU owns that cycle. Then rd_pend clears.
- Stall rule: in any cycle with cpu_req=1, the engine state and counters hold, and no engine access occurs.
- Completion: the cycle after the final engine write, busy=0, done=1 for exactly one cycle, and cmd_ready=1.
- Uncontended latencies, counted from acceptance to the done cycle: CLEAR = 4096+1 cycles; SCROLL_UP = 3968*2 + 128 + 1 = 8065 cycles. Each CPU-owned cycle during the command adds exactly 1.
- Coherence: a CPU write to a row during a scroll may be overwritten or moved. This is software's responsibility and is not checked in hardware.
- Address arithmetic is unsigned AW bits. src-COLS never underflows because src>=COLS.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with random inputs. Then busy=0, done=0, mem_we=0, cmd_ready=1. Assert reset mid-CLEAR at word 1000: words 0..999 hold the fill, 1000+ are unchanged, and busy=0 the next cycle.
2. CLEAR, cmd_fill=0x00F0_0020, no CPU traffic: all 4096 words read back 0x00F0_0020. done pulses exactly 4097 cycles after acceptance.
3. SCROLL_UP, preloaded word[a]=a: for a<3968, word[a]=a+128. Words 3968..4095 equal cmd_fill=0x0000_0041. done arrives at 8065 cycles.
4. SCROLL_UP with a CPU read of addr 5 every 3rd cycle: the scroll result matches scenario 3. Each CPU read returns the current word[5] one cycle later. Total latency is 8065 plus the number of CPU cycles.
5. CPU read on the cycle immediately after every engine read (worst-case steal): hold is still captured correctly and the final memory is correct.
6. cmd_valid held high with cmd_op=0 during an active scroll: cmd_ready=0 and the command is ignored. The scroll result is unchanged, and the next command is accepted the cycle after done.
